// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 32-point radix-2 FFT stage scheduler:
//   - scheduler state encoding
//   - frame geometry (32 points, 4 butterfly groups of 4 lanes)
//   - twiddle ROM W32^k, k = 4*group + lane, packed {re[15:0], im[15:0]}
//     in signed Q1.15 (1.0 saturated to 0x7FFF)
//   - lane pack/unpack helpers shared by the scheduler datapath
// -----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        UNLOAD = 2'd3
    } sched_state_e;

    localparam int FRAME_SIZE   = 32;
    localparam int NUM_GROUPS   = 4;
    localparam int NUM_LANES    = 4;
    localparam int TWIDDLE_BITS = 32;

    // Twiddle W32^(4g+k) = cos(2*pi*n/32) - j*sin(2*pi*n/32), n = 4g+k.
    function automatic logic [TWIDDLE_BITS-1:0] twiddle(input logic [1:0] group,
                                                        input logic [1:0] lane);
        logic [TWIDDLE_BITS-1:0] w;
        case ({group, lane})
            4'd0:    w = 32'h7FFF_0000;
            4'd1:    w = 32'h7D89_E707;
            4'd2:    w = 32'h7641_CF05;
            4'd3:    w = 32'h6A6D_B8E4;
            4'd4:    w = 32'h5A82_A57E;
            4'd5:    w = 32'h471C_9593;
            4'd6:    w = 32'h30FB_89BF;
            4'd7:    w = 32'h18F9_8277;
            4'd8:    w = 32'h0000_8001;
            4'd9:    w = 32'hE707_8277;
            4'd10:   w = 32'hCF05_89BF;
            4'd11:   w = 32'hB8E4_9593;
            4'd12:   w = 32'hA57E_A57E;
            4'd13:   w = 32'h9593_B8E4;
            4'd14:   w = 32'h89BF_CF05;
            4'd15:   w = 32'h8277_E707;
            default: w = 32'h7FFF_0000;
        endcase
        return w;
    endfunction

    // Bit offset of a lane inside a packed 4-lane bus, lane 0 in the LSBs.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Frame index of the upper-half ("m") operand of group g, lane k: 4g+k.
    function automatic logic [4:0] m_index(input logic [1:0] group,
                                           input logic [1:0] lane);
        return {1'b0, group, lane};
    endfunction

    // Frame index of the lower-half ("n") operand of group g, lane k: 16+4g+k.
    function automatic logic [4:0] n_index(input logic [1:0] group,
                                           input logic [1:0] lane);
        return {1'b1, group, lane};
    endfunction

endpackage

// File: rtl/fft_sched_tag_pipe.sv
// -----------------------------------------------------------------------------
// fft_sched_tag_pipe
// Delay line of depth P_DEPTH carrying {valid, group} alongside the shared
// butterfly unit so the scheduler knows which group a result belongs to.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears all tags)
//   in_valid     group issued this cycle
//   in_group     index of the issued group
//   out_valid    result for out_group is present at the unit outputs
//   out_group    group index delayed by P_DEPTH cycles
// -----------------------------------------------------------------------------
module fft_sched_tag_pipe #(
    parameter int P_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_group,
    output logic       out_valid,
    output logic [1:0] out_group
);

    logic [P_DEPTH-1:0] valid_r;
    logic [1:0]         group_r [P_DEPTH];

    // Shift the tag one stage per cycle; reset empties every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < P_DEPTH; i++) begin
                group_r[i] <= 2'd0;
            end
        end else begin
            valid_r[0] <= in_valid;
            group_r[0] <= in_group;
            for (int i = 1; i < P_DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                group_r[i] <= group_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[P_DEPTH-1];
    assign out_group = group_r[P_DEPTH-1];

endmodule

// File: rtl/fft_stage_scheduler.sv
// -----------------------------------------------------------------------------
// fft_stage_scheduler
// Shares one 4-lane butterfly unit across a 32-point radix-2 FFT stage.
// A frame of 32 samples is loaded serially, issued as 4 groups (one per
// cycle), the unit results are captured after P_MUL_LATENCY cycles and the
// 32 results are streamed out in natural order. Single-buffered: the next
// frame loads only after the last result has been handed off.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   i_s_valid/data/last      serial sample input, o_s_ready accept
//   o_bf_issue/group         group issue strobe and index to the unit
//   o_bf_m, o_bf_n           operands d[4g+k], d[16+4g+k] per lane k
//   i_bf_res_p, i_bf_res_m   unit results for X[4g+k], X[16+4g+k]
//   o_m_valid/data/index/last, i_m_ready   result output stream
//   o_busy                   high in every state other than LOAD
//   o_frame_err              sticky: i_s_last disagreed with sample count
// -----------------------------------------------------------------------------
module fft_stage_scheduler
    import fft_pkg::*;
#(
    parameter int P_REAL_BITS   = 15,
    parameter int P_SAMPLE_BITS = 2 * P_REAL_BITS,
    parameter int P_RESULT_BITS = 32,
    parameter int P_MUL_LATENCY = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         i_s_valid,
    input  logic [P_SAMPLE_BITS-1:0]     i_s_data,
    input  logic                         i_s_last,
    output logic                         o_s_ready,
    output logic                         o_bf_issue,
    output logic [1:0]                   o_bf_group,
    output logic [4*P_SAMPLE_BITS-1:0]   o_bf_m,
    output logic [4*P_SAMPLE_BITS-1:0]   o_bf_n,
    input  logic [4*P_RESULT_BITS-1:0]   i_bf_res_p,
    input  logic [4*P_RESULT_BITS-1:0]   i_bf_res_m,
    output logic                         o_m_valid,
    output logic [P_RESULT_BITS-1:0]     o_m_data,
    output logic [4:0]                   o_m_index,
    output logic                         o_m_last,
    input  logic                         i_m_ready,
    output logic                         o_busy,
    output logic                         o_frame_err
);

    sched_state_e state_r;
    sched_state_e state_s;
    // One counter serves as load count, issue group and unload index,
    // since the three phases never overlap.
    logic [4:0]   cnt_r;
    logic [4:0]   cnt_s;
    logic         frame_err_r;
    logic         err_set_s;
    logic         s_accept_s;
    logic         issue_s;
    logic         tag_valid_s;
    logic [1:0]   tag_group_s;

    logic [P_SAMPLE_BITS-1:0] buf_r [FRAME_SIZE];
    logic [P_RESULT_BITS-1:0] res_r [FRAME_SIZE];

    assign s_accept_s = (state_r == LOAD) && i_s_valid;
    assign issue_s    = (state_r == ISSUE);
    // The frame boundary is count based; i_s_last only raises the error flag.
    assign err_set_s  = s_accept_s && ((cnt_r == 5'd31) != i_s_last);

    fft_sched_tag_pipe #(
        .P_DEPTH (P_MUL_LATENCY)
    ) u_tag_pipe (
        .clk       (CLK),
        .rst       (RST),
        .in_valid  (issue_s),
        .in_group  (cnt_r[1:0]),
        .out_valid (tag_valid_s),
        .out_group (tag_group_s)
    );

    // State, shared counter and sticky frame error registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= LOAD;
            cnt_r       <= 5'd0;
            frame_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (err_set_s) begin
                frame_err_r <= 1'b1;
            end
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            LOAD: begin
                if (s_accept_s) begin
                    if (cnt_r == 5'd31) begin
                        state_s = ISSUE;
                        cnt_s   = 5'd0;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ISSUE: begin
                if (cnt_r == 5'd3) begin
                    state_s = DRAIN;
                    cnt_s   = 5'd0;
                end else begin
                    cnt_s = cnt_r + 5'd1;
                end
            end
            DRAIN: begin
                // Group 3 is the last one in flight; its capture ends the drain.
                if (tag_valid_s && (tag_group_s == 2'd3)) begin
                    state_s = UNLOAD;
                    cnt_s   = 5'd0;
                end else begin
                    state_s = DRAIN;
                end
            end
            UNLOAD: begin
                if (i_m_ready) begin
                    if (cnt_r == 5'd31) begin
                        state_s = LOAD;
                        cnt_s   = 5'd0;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = LOAD;
                cnt_s   = 5'd0;
            end
        endcase
    end

    // Sample buffer write; contents need no reset.
    always_ff @(posedge CLK) begin
        if (!RST && s_accept_s) begin
            buf_r[cnt_r] <= i_s_data;
        end
    end

    // Result capture when a tagged group emerges from the unit pipeline.
    always_ff @(posedge CLK) begin
        if (tag_valid_s) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                res_r[m_index(tag_group_s, 2'(k))] <=
                    i_bf_res_p[lane_lsb(k, P_RESULT_BITS) +: P_RESULT_BITS];
                res_r[n_index(tag_group_s, 2'(k))] <=
                    i_bf_res_m[lane_lsb(k, P_RESULT_BITS) +: P_RESULT_BITS];
            end
        end
    end

    // Operand lanes for the group being issued, zero otherwise.
    always_comb begin
        o_bf_m = '0;
        o_bf_n = '0;
        if (issue_s) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                o_bf_m[lane_lsb(k, P_SAMPLE_BITS) +: P_SAMPLE_BITS] =
                    buf_r[m_index(cnt_r[1:0], 2'(k))];
                o_bf_n[lane_lsb(k, P_SAMPLE_BITS) +: P_SAMPLE_BITS] =
                    buf_r[n_index(cnt_r[1:0], 2'(k))];
            end
        end else begin
            o_bf_m = '0;
            o_bf_n = '0;
        end
    end

    // Result stream fields; they hold while stalled because cnt_r holds.
    always_comb begin
        o_m_valid = 1'b0;
        o_m_data  = '0;
        o_m_index = 5'd0;
        o_m_last  = 1'b0;
        if (state_r == UNLOAD) begin
            o_m_valid = 1'b1;
            o_m_data  = res_r[cnt_r];
            o_m_index = cnt_r;
            o_m_last  = (cnt_r == 5'd31);
        end else begin
            o_m_valid = 1'b0;
        end
    end

    assign o_s_ready   = (state_r == LOAD);
    assign o_busy      = (state_r != LOAD);
    assign o_bf_issue  = issue_s;
    assign o_bf_group  = issue_s ? cnt_r[1:0] : 2'd0;
    assign o_frame_err = frame_err_r;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for fft_stage_scheduler. A stub butterfly unit returns
// res_p = m + 0x100 and res_m = n + 0x200 after L cycles, so the expected
// output frame is X[i] = d[i] + 0x100 (i < 16) and d[i] + 0x200 (i >= 16).
// Accepted samples are mirrored by a monitor that pushes expected results
// into a scoreboard queue; the output monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_fft_stage_scheduler;

    localparam int L  = 2;
    localparam int SB = 30;
    localparam int RB = 32;

    typedef struct packed {
        logic [RB-1:0] data;
        logic [4:0]    idx;
        logic          last;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RST;
    logic            i_s_valid;
    logic [SB-1:0]   i_s_data;
    logic            i_s_last;
    logic            o_s_ready;
    logic            o_bf_issue;
    logic [1:0]      o_bf_group;
    logic [4*SB-1:0] o_bf_m;
    logic [4*SB-1:0] o_bf_n;
    logic [4*RB-1:0] i_bf_res_p;
    logic [4*RB-1:0] i_bf_res_m;
    logic            o_m_valid;
    logic [RB-1:0]   o_m_data;
    logic [4:0]      o_m_index;
    logic            o_m_last;
    logic            i_m_ready = 1'b1;
    logic            o_busy;
    logic            o_frame_err;

    fft_stage_scheduler #(
        .P_REAL_BITS   (15),
        .P_SAMPLE_BITS (SB),
        .P_RESULT_BITS (RB),
        .P_MUL_LATENCY (L)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_s_valid   (i_s_valid),
        .i_s_data    (i_s_data),
        .i_s_last    (i_s_last),
        .o_s_ready   (o_s_ready),
        .o_bf_issue  (o_bf_issue),
        .o_bf_group  (o_bf_group),
        .o_bf_m      (o_bf_m),
        .o_bf_n      (o_bf_n),
        .i_bf_res_p  (i_bf_res_p),
        .i_bf_res_m  (i_bf_res_m),
        .o_m_valid   (o_m_valid),
        .o_m_data    (o_m_data),
        .o_m_index   (o_m_index),
        .o_m_last    (o_m_last),
        .i_m_ready   (i_m_ready),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- stub shared unit: L-cycle latency ----------------
    logic [4*RB-1:0] stub_p [L+1] = '{default: '0};
    logic [4*RB-1:0] stub_m [L+1] = '{default: '0};

    always @(negedge CLK) begin
        for (int j = L; j > 0; j--) begin
            stub_p[j] = stub_p[j-1];
            stub_m[j] = stub_m[j-1];
        end
        for (int k = 0; k < 4; k++) begin
            stub_p[0][k*RB +: RB] = {2'b00, o_bf_m[k*SB +: SB]} + 32'h100;
            stub_m[0][k*RB +: RB] = {2'b00, o_bf_n[k*SB +: SB]} + 32'h200;
        end
    end

    assign i_bf_res_p = stub_p[L];
    assign i_bf_res_m = stub_m[L];

    // ---------------- downstream ready pattern ----------------
    int         bp_mode = 0;
    int         bp_cnt  = 0;
    logic [3:0] bp_pat  = 4'b1001;   // read LSB first: 1,0,0,1

    always @(posedge CLK) begin
        #1;
        case (bp_mode)
            1:       i_m_ready = bp_pat[bp_cnt % 4];
            2:       i_m_ready = 1'($urandom_range(0, 1));
            default: i_m_ready = 1'b1;
        endcase
        bp_cnt = bp_cnt + 1;
    end

    // ---------------- reference model + scoreboard ----------------
    exp_t          sb_q[$];
    logic [SB-1:0] load_buf  [32];
    logic [SB-1:0] cur_frame [32];
    int            load_n        = 0;
    logic          exp_ready     = 1'b1;
    logic          exp_err       = 1'b0;
    logic          frame_pending = 1'b0;
    int            issue_g       = 0;
    int            cyc           = 0;
    int            first_acc_cyc = 0;
    int            last_acc_cyc  = 0;
    logic          prev_valid    = 1'b0;
    int            hs_cnt        = 0;
    int            frames_in     = 0;

    always @(negedge CLK) begin
        logic popped_last;
        exp_t e;
        popped_last = 1'b0;
        cyc = cyc + 1;

        chk("s_ready", o_s_ready, exp_ready);
        chk("busy", o_busy, !exp_ready);
        chk("frame_err", o_frame_err, exp_err);

        if (o_bf_issue) begin
            if (!frame_pending) begin
                chk("spurious_issue", o_bf_issue, 1'b0);
            end else begin
                chk("bf_group", o_bf_group, issue_g);
                if (issue_g == 0) chk("issue_start_cyc", cyc, last_acc_cyc + 1);
                for (int k = 0; k < 4; k++) begin
                    chk("bf_m_lane", o_bf_m[k*SB +: SB], cur_frame[4*issue_g + k]);
                    chk("bf_n_lane", o_bf_n[k*SB +: SB], cur_frame[16 + 4*issue_g + k]);
                end
                issue_g = issue_g + 1;
                if (issue_g == 4) begin
                    frame_pending = 1'b0;
                    issue_g = 0;
                end
            end
        end

        if (o_m_valid) begin
            if (!prev_valid) begin
                // 4 issue cycles + L unit latency + 1 capture-to-unload cycle
                chk("first_valid_latency", cyc, last_acc_cyc + 4 + L + 1);
                if (last_acc_cyc - first_acc_cyc == 31)
                    chk("first_valid_from_s0", cyc, first_acc_cyc + 32 + 4 + L);
            end
            if (sb_q.size() == 0) begin
                chk("unexpected_output", o_m_valid, 1'b0);
            end else begin
                chk("m_data", o_m_data, sb_q[0].data);
                chk("m_index", o_m_index, sb_q[0].idx);
                chk("m_last", o_m_last, sb_q[0].last);
                if (i_m_ready && !RST) begin
                    popped_last = sb_q[0].last;
                    void'(sb_q.pop_front());
                    hs_cnt = hs_cnt + 1;
                end
            end
        end
        prev_valid = o_m_valid;

        // Apply this cycle's inputs to the model state.
        if (RST) begin
            exp_ready     = 1'b1;
            exp_err       = 1'b0;
            load_n        = 0;
            frame_pending = 1'b0;
            issue_g       = 0;
            prev_valid    = 1'b0;
            sb_q.delete();
        end else begin
            if (exp_ready && i_s_valid) begin
                if (((load_n == 31) ? 1'b1 : 1'b0) != i_s_last) exp_err = 1'b1;
                if (load_n == 0) first_acc_cyc = cyc;
                load_buf[load_n] = i_s_data;
                if (load_n == 31) begin
                    for (int i = 0; i < 32; i++) begin
                        cur_frame[i] = load_buf[i];
                        e.data = {2'b00, load_buf[i]} + ((i < 16) ? 32'h100 : 32'h200);
                        e.idx  = 5'(i);
                        e.last = (i == 31);
                        sb_q.push_back(e);
                    end
                    frames_in     = frames_in + 1;
                    frame_pending = 1'b1;
                    issue_g       = 0;
                    exp_ready     = 1'b0;
                    last_acc_cyc  = cyc;
                    load_n        = 0;
                end else begin
                    load_n = load_n + 1;
                end
            end
            if (popped_last) exp_ready = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    logic [SB-1:0] stim [32];

    task automatic drive_sample(input logic [SB-1:0] d, input logic l);
        int w;
        w = 0;
        i_s_valid = 1'b1;
        i_s_data  = d;
        i_s_last  = l;
        @(negedge CLK);
        while (!o_s_ready && w < 3000) begin
            w = w + 1;
            @(negedge CLK);
        end
        if (w >= 3000) chk("ready_timeout", w, 0);
        @(posedge CLK);
        #1;
        i_s_valid = 1'b0;
        i_s_last  = 1'b0;
    endtask

    task automatic send_frame(input int count, input int last_pos, input int stall_at);
        for (int n = 0; n < count; n++) begin
            if (n == stall_at) begin
                i_s_valid = 1'b0;
                repeat (5) @(posedge CLK);
                #1;
            end
            drive_sample(stim[n], n == last_pos);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!(exp_ready && !frame_pending && sb_q.size() == 0) && w < 3000) begin
            @(negedge CLK);
            w = w + 1;
        end
        if (w >= 3000) chk("idle_timeout", w, 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"},  o_s_ready,   1'b1);
        chk({tag, "_bf_issue"}, o_bf_issue,  1'b0);
        chk({tag, "_bf_group"}, o_bf_group,  2'd0);
        chk({tag, "_bf_m"},     o_bf_m,      '0);
        chk({tag, "_bf_n"},     o_bf_n,      '0);
        chk({tag, "_m_valid"},  o_m_valid,   1'b0);
        chk({tag, "_m_data"},   o_m_data,    '0);
        chk({tag, "_m_index"},  o_m_index,   5'd0);
        chk({tag, "_m_last"},   o_m_last,    1'b0);
        chk({tag, "_busy"},     o_busy,      1'b0);
        chk({tag, "_frame_err"}, o_frame_err, 1'b0);
    endtask

    task automatic fill_ramp();
        for (int n = 0; n < 32; n++) stim[n] = SB'(n);
    endtask

    task automatic fill_random();
        for (int n = 0; n < 32; n++) stim[n] = SB'($urandom);
    endtask

    initial begin
        RST       = 1'b1;
        i_s_valid = 1'b0;
        i_s_data  = '0;
        i_s_last  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("por");
        @(posedge CLK);
        #1;

        // Ramp frame, downstream always ready.
        bp_mode = 0;
        fill_ramp();
        send_frame(32, 31, -1);
        wait_idle();

        // Ramp frame with ready pattern 1,0,0,1.
        bp_mode = 1;
        fill_ramp();
        send_frame(32, 31, -1);
        wait_idle();

        // Random frame with a 5-cycle source stall mid-load, random ready.
        bp_mode = 2;
        fill_random();
        send_frame(32, 31, 12);
        wait_idle();

        // Reset after 17 samples, then a clean ramp frame.
        bp_mode = 0;
        fill_random();
        send_frame(17, -1, -1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("mid_rst");
        @(posedge CLK);
        #1;
        fill_ramp();
        send_frame(32, 31, -1);
        wait_idle();

        // i_s_last early at sample 10: sticky error, frame still 32 long.
        fill_ramp();
        send_frame(32, 10, -1);
        wait_idle();

        // Two clean random frames back to back with random ready.
        bp_mode = 2;
        fill_random();
        send_frame(32, 31, -1);
        fill_random();
        send_frame(32, 31, -1);
        wait_idle();

        chk("scoreboard_empty", sb_q.size(), 0);
        chk("handshakes_total", hs_cnt, 32 * frames_in);
        chk("frames_completed", frames_in, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
